// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by core stores,
// bit-serialiser on tx, combinational status word for polling.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_we,
  output logic [31:0] uart_rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CNW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(CLK_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CNW-1:0] fcnt_q, fcnt_d;
  logic [1:0]     st_q, st_d;
  logic [CW-1:0]  bcnt_q, bcnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shf_q, shf_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;
  logic           irq_q, irq_d;

  logic wr_data, wr_stat;
  logic fempty, ffull, bit_end;
  logic push, pop;
  logic [31:0] cnt32;
  logic [3:0]  cnt_sat;
  logic unused_ok;

  assign wr_data = data_we[0] && (data_addr == BASE_ADDR);
  assign wr_stat = data_we[0] && (data_addr == BASE_ADDR + 32'd4);
  assign fempty  = (fcnt_q == '0);
  assign ffull   = (fcnt_q == CNW'(FIFO_DEPTH));
  assign bit_end = (bcnt_q == CW'(CLK_DIV - 1));

  // A pop frees a slot on the same edge, so a full FIFO can still accept
  assign push = wr_data && (!ffull || pop);

  always_comb begin
    st_d   = st_q;
    bcnt_d = bcnt_q + CW'(1);
    idx_d  = idx_q;
    shf_d  = shf_q;
    tx_d   = tx_q;
    pop    = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        bcnt_d = '0;
        tx_d   = 1'b1;
        if (!fempty) begin
          pop   = 1'b1;
          shf_d = mem_q[rptr_q];
          st_d  = S_START;
          tx_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          bcnt_d = '0;
          idx_d  = '0;
          st_d   = S_DATA;
          tx_d   = shf_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (idx_q == 3'd7) begin
            st_d = S_STOP;
            tx_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            shf_d = shf_q >> 1;
            tx_d  = shf_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (!fempty) begin
            pop   = 1'b1;
            shf_d = mem_q[rptr_q];
            st_d  = S_START;
            tx_d  = 1'b0;
          end else begin
            st_d = S_IDLE;
          end
        end
      end
      default: begin
        st_d = S_IDLE;
        tx_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    fcnt_d = fcnt_q + CNW'(push) - CNW'(pop);
    ovf_d  = ovf_q;
    if (wr_data && !push)
      ovf_d = 1'b1;
    else if (wr_stat && data_wdata[3])
      ovf_d = 1'b0;
    irq_d = (fcnt_d == '0) && (st_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= data_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      st_q   <= S_IDLE;
      bcnt_q <= '0;
      idx_q  <= '0;
      shf_q  <= '0;
      tx_q   <= 1'b1;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      fcnt_q <= fcnt_d;
      st_q   <= st_d;
      bcnt_q <= bcnt_d;
      idx_q  <= idx_d;
      shf_q  <= shf_d;
      tx_q   <= tx_d;
      ovf_q  <= ovf_d;
      irq_q  <= irq_d;
    end
  end

  assign cnt32   = 32'(fcnt_q);
  assign cnt_sat = (cnt32 > 32'd15) ? 4'hf : cnt32[3:0];

  assign uart_rdata = (data_addr == BASE_ADDR + 32'd4)
    ? {24'h0, cnt_sat, ovf_q, (st_q != S_IDLE), fempty, ffull}
    : 32'h0;

  assign tx        = tx_q;
  assign irq_empty = irq_q;
  assign unused_ok = ^{data_wdata[31:8], data_we[3:1]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at CLK_DIV=4: frames, back-to-back,
// overflow/clear, status decode, byte-enable filtering, mid-frame reset.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] STAT = 32'h1000_0004;

  logic        clk;
  logic        reset;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_we;
  logic [31:0] uart_rdata;
  logic        tx;
  logic        irq_empty;

  int n_run;
  int n_fail;

  uart_tx_mmio #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_we   (data_we),
    .uart_rdata(uart_rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] we);
    data_addr  = a;
    data_wdata = d;
    data_we    = we;
    tick();
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_we    = 4'h0;
  endtask

  task automatic rd_stat(output logic [31:0] v);
    data_addr = STAT;
    #1;
    v = uart_rdata;
    data_addr = 32'h0;
  endtask

  task automatic cap(input int n, output logic [79:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v[i] = tx;
      tick();
    end
  endtask

  function automatic logic [39:0] frm(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = f[i/4];
    return r;
  endfunction

  logic [79:0] v;
  logic [31:0] s;
  int          k;

  initial begin
    n_run      = 0;
    n_fail     = 0;
    reset      = 1'b0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_we    = 4'h0;
    tick();
    tick();
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_irq", 64'(irq_empty), 64'd1);
    rd_stat(s);
    chk("rst_stat", 64'(s), 64'h2);
    reset = 1'b1;
    tick();

    rd_stat(s);
    chk("idle_stat", 64'(s), 64'h2);
    data_addr = 32'h1000_0008;
    #1;
    chk("other_addr", 64'(uart_rdata), 64'h0);
    data_addr = 32'h0;

    // Single 0x55 frame
    store(BASE, 32'h55, 4'b0001);
    chk("lat_pre_tx", 64'(tx), 64'd1);
    chk("lat_pre_irq", 64'(irq_empty), 64'd0);
    tick();
    cap(40, v);
    chk("frame55", 64'(v[39:0]), 64'(frm(8'h55)));
    chk("f55_irq", 64'(irq_empty), 64'd1);
    rd_stat(s);
    chk("f55_stat", 64'(s), 64'h2);

    // Back-to-back frames, no idle gap
    store(BASE, 32'h41, 4'b0001);
    store(BASE, 32'h42, 4'b0001);
    cap(80, v);
    chk("b2b_41", 64'(v[39:0]), 64'(frm(8'h41)));
    chk("b2b_42", 64'(v[79:40]), 64'(frm(8'h42)));
    chk("b2b_irq", 64'(irq_empty), 64'd1);

    // Overflow: one byte goes into the shifter, then 9 more
    store(BASE, 32'hA0, 4'b0001);
    for (int i = 0; i < 9; i++)
      store(BASE, 32'(8'hB0 + i), 4'b0001);
    rd_stat(s);
    chk("ovf_stat", 64'(s), 64'h8D);
    chk("ovf_irq", 64'(irq_empty), 64'd0);
    store(STAT, 32'h8, 4'b0001);
    rd_stat(s);
    chk("ovf_clr", 64'(s), 64'h85);
    for (k = 0; k < 600 && !irq_empty; k++) tick();
    chk("drain_irq", 64'(irq_empty), 64'd1);
    rd_stat(s);
    chk("drain_stat", 64'(s), 64'h2);

    // Byte enable without lane 0, and a push to a foreign address
    store(BASE, 32'h33, 4'b0010);
    store(32'h1000_0008, 32'h33, 4'b0001);
    cap(8, v);
    chk("we_tx", 64'(v[7:0]), 64'hFF);
    rd_stat(s);
    chk("we_stat", 64'(s), 64'h2);

    // Reset during DATA bit 3 of 0x35 (bit3=0), second byte queued
    store(BASE, 32'h35, 4'b0001);
    store(BASE, 32'h77, 4'b0001);
    for (int i = 0; i < 16; i++) tick();
    chk("pre_rst_bit3", 64'(tx), 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", 64'(tx), 64'd1);
    rd_stat(s);
    chk("mid_rst_stat", 64'(s), 64'h2);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_irq", 64'(irq_empty), 64'd1);
    cap(8, v);
    chk("post_rst_tx", 64'(v[7:0]), 64'hFF);
    rd_stat(s);
    chk("post_rst_stat", 64'(s), 64'h2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
